// File: rtl/reorder_pkg.sv
// Shared constants and FSM state type for the RS(544,522) reorder/Forney event path.
package reorder_pkg;

  localparam int unsigned RS_N = 544;
  localparam int unsigned RS_T = 11;
  localparam int unsigned RS_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    JUDGE,
    DRAIN,
    DONE
  } evt_tx_state_e;

endpackage

// File: rtl/evt_fifo.sv
// Synchronous fall-through FIFO holding per-frame error events; flush wins over push.
module evt_fifo #(
  parameter int unsigned DEPTH = 11,
  parameter int unsigned WIDTH = 20
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int unsigned   AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   LW       = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [LW-1:0] DEPTH_C  = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign level_o = count_q;
  assign rdata_o = mem[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + LW'(1);
      else if (do_pop && !do_push) count_q <= count_q - LW'(1);
    end
  end

endmodule

// File: rtl/forney_evt_tx.sv
// Forney event transmitter: collects Chien hits per frame, issues the correctability
// verdict, drains accepted events in order and closes each frame with one done pulse.
module forney_evt_tx
  import reorder_pkg::*;
#(
  parameter int unsigned W = RS_W,
  parameter int unsigned N = RS_N,
  parameter int unsigned T = RS_T
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         chien_start_i,
  input  logic [4:0]   lambda_deg_i,
  input  logic         lambda_fail_i,
  input  logic         chien_vld_i,
  input  logic         chien_hit_i,
  input  logic [9:0]   chien_pos_i,
  input  logic [W-1:0] chien_y_i,
  input  logic         chien_last_i,
  output logic         chien_rdy_o,
  output logic         ecc_valid_o,
  output logic         exceed_o,
  output logic         forney_vld_o,
  output logic [9:0]   forney_pos_o,
  output logic [W-1:0] forney_y_o,
  input  logic         forney_rdy_i,
  output logic         recorrect_done_o,
  output logic         proto_err_o
);

  localparam int unsigned   CW  = $clog2(T + 2);
  localparam int unsigned   LW  = $clog2(T + 1);
  localparam int unsigned   DW  = 10 + W;
  localparam int unsigned   GW  = (CW > 5) ? CW : 5;
  localparam logic [CW-1:0] T_C = CW'(T);
  localparam logic [9:0]    N_C = 10'(N);

  evt_tx_state_e state_q, state_d;
  logic [4:0]    deg_q, deg_d;
  logic [CW-1:0] hit_cnt_q, hit_cnt_d;
  logic          fail_q, fail_d, oor_q, oor_d, proto_q, proto_d;
  logic          ecc_valid_q, ecc_valid_d, exceed_q, exceed_d, done_q, done_d;
  logic          fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full;
  logic [DW-1:0] fifo_head;
  logic [LW-1:0] fifo_level;
  logic          beat_hit, pos_ok, drain_vld;

  assign beat_hit  = chien_vld_i && chien_hit_i;
  assign pos_ok    = (chien_pos_i < N_C);
  assign drain_vld = (state_q == DRAIN) && !fifo_empty;
  assign fifo_pop  = drain_vld && forney_rdy_i;

  evt_fifo #(
    .DEPTH(T),
    .WIDTH(DW)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .flush_i(fifo_flush),
    .push_i (fifo_push),
    .wdata_i({chien_pos_i, chien_y_i}),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_head),
    .empty_o(fifo_empty),
    .full_o (fifo_full),
    .level_o(fifo_level)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      deg_q       <= '0;
      fail_q      <= 1'b0;
      hit_cnt_q   <= '0;
      oor_q       <= 1'b0;
      proto_q     <= 1'b0;
      ecc_valid_q <= 1'b0;
      exceed_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      deg_q       <= deg_d;
      fail_q      <= fail_d;
      hit_cnt_q   <= hit_cnt_d;
      oor_q       <= oor_d;
      proto_q     <= proto_d;
      ecc_valid_q <= ecc_valid_d;
      exceed_q    <= exceed_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    deg_d      = deg_q;
    fail_d     = fail_q;
    hit_cnt_d  = hit_cnt_q;
    oor_d      = oor_q;
    proto_d    = proto_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (chien_vld_i) proto_d = 1'b1;
        if (chien_start_i) begin
          deg_d      = lambda_deg_i;
          fail_d     = lambda_fail_i;
          hit_cnt_d  = '0;
          oor_d      = 1'b0;
          fifo_flush = 1'b1;
          state_d    = COLLECT;
        end
      end
      COLLECT: begin
        if (chien_start_i) proto_d = 1'b1;
        // Hits beyond T are still counted (saturating at T+1) so the verdict sees overflow.
        if (beat_hit) begin
          if (!pos_ok) oor_d = 1'b1;
          if (hit_cnt_q < T_C) fifo_push = pos_ok && !fifo_full;
          if (hit_cnt_q <= T_C) hit_cnt_d = hit_cnt_q + CW'(1);
        end
        if (chien_vld_i && chien_last_i) state_d = JUDGE;
      end
      JUDGE: begin
        if (exceed_q || (hit_cnt_q == '0)) begin
          fifo_flush = 1'b1;
          state_d    = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty || (fifo_pop && (fifo_level == LW'(1)))) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Verdict and done are registered off the next state so they line up with JUDGE/DONE.
  always_comb begin
    chien_rdy_o = (state_q == IDLE) || (state_q == COLLECT);
    ecc_valid_d = (state_d == JUDGE);
    exceed_d    = (state_d == JUDGE) &&
                  (fail_q || oor_d || (hit_cnt_d > T_C) || (GW'(hit_cnt_d) != GW'(deg_q)));
    done_d      = (state_d == DONE);
  end

  assign ecc_valid_o      = ecc_valid_q;
  assign exceed_o         = exceed_q;
  assign recorrect_done_o = done_q;
  assign proto_err_o      = proto_q;
  assign forney_vld_o     = drain_vld;
  assign forney_pos_o     = drain_vld ? fifo_head[DW-1 -: 10] : '0;
  assign forney_y_o       = drain_vld ? fifo_head[W-1:0] : '0;

endmodule

// File: tb/tb_forney_evt_tx.sv
// Self-checking bench for forney_evt_tx: directed table, hand sequences and random frames
// checked against a frame-level reference model.
module tb_forney_evt_tx;
  localparam int unsigned W = 10;
  localparam int unsigned N = 544;
  localparam int unsigned T = 11;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         chien_start_i = 1'b0;
  logic [4:0]   lambda_deg_i = '0;
  logic         lambda_fail_i = 1'b0;
  logic         chien_vld_i = 1'b0;
  logic         chien_hit_i = 1'b0;
  logic [9:0]   chien_pos_i = '0;
  logic [W-1:0] chien_y_i = '0;
  logic         chien_last_i = 1'b0;
  logic         chien_rdy_o, ecc_valid_o, exceed_o, forney_vld_o;
  logic [9:0]   forney_pos_o;
  logic [W-1:0] forney_y_o;
  logic         forney_rdy_i = 1'b1;
  logic         recorrect_done_o, proto_err_o;

  forney_evt_tx #(.W(W), .N(N), .T(T)) dut (
    .clk_i(clk), .rst_i(rst_i), .chien_start_i(chien_start_i), .lambda_deg_i(lambda_deg_i),
    .lambda_fail_i(lambda_fail_i), .chien_vld_i(chien_vld_i), .chien_hit_i(chien_hit_i),
    .chien_pos_i(chien_pos_i), .chien_y_i(chien_y_i), .chien_last_i(chien_last_i),
    .chien_rdy_o(chien_rdy_o), .ecc_valid_o(ecc_valid_o), .exceed_o(exceed_o),
    .forney_vld_o(forney_vld_o), .forney_pos_o(forney_pos_o), .forney_y_o(forney_y_o),
    .forney_rdy_i(forney_rdy_i), .recorrect_done_o(recorrect_done_o), .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Frame contents and downstream ready schedule (indexed by cycle offset from last beat)
  logic [9:0]   h_pos[$];
  logic [W-1:0] h_y[$];
  bit           rdy_pat[512];

  function automatic bit rdy_at(input int off);
    if (off < 0 || off >= 512) return 1'b1;
    return rdy_pat[off];
  endfunction

  function automatic void rdy_all_ones();
    for (int k = 0; k < 512; k++) rdy_pat[k] = 1'b1;
  endfunction

  // Reference verdict from the frame-level rules
  function automatic bit ref_exceed(input logic [4:0] deg, input bit fail);
    bit oor = 1'b0;
    foreach (h_pos[i]) if (h_pos[i] >= N) oor = 1'b1;
    return fail || oor || (h_pos.size() > T) || (h_pos.size() != int'(deg));
  endfunction

  // Output monitor
  int           v_cyc[$];
  bit           v_exc[$];
  int           e_cyc[$];
  logic [9:0]   e_pos[$];
  logic [W-1:0] e_y[$];
  int           d_cyc[$];
  bit           prev_stall = 1'b0;
  logic [9:0]   prev_pos;
  logic [W-1:0] prev_y;

  always @(negedge clk) begin
    if (prev_stall) begin
      chk("stall_vld_hold", forney_vld_o, 1);
      chk("stall_pos_hold", forney_pos_o, prev_pos);
      chk("stall_y_hold", forney_y_o, prev_y);
    end
    prev_stall <= forney_vld_o && !forney_rdy_i && !rst_i;
    prev_pos   <= forney_pos_o;
    prev_y     <= forney_y_o;
    if (ecc_valid_o) begin
      v_cyc.push_back(cyc);
      v_exc.push_back(exceed_o);
    end
    if (forney_vld_o && forney_rdy_i && !rst_i) begin
      e_cyc.push_back(cyc);
      e_pos.push_back(forney_pos_o);
      e_y.push_back(forney_y_o);
    end
    if (recorrect_done_o) d_cyc.push_back(cyc);
  end

  task automatic clear_mon();
    v_cyc.delete(); v_exc.delete(); e_cyc.delete(); e_pos.delete(); e_y.delete(); d_cyc.delete();
  endtask

  task automatic drive_frame(input logic [4:0] deg, input bit fail, input bit last_hit,
                             input bit gaps, output int c);
    int n;
    n = 0;
    c = 0;
    clear_mon();
    forney_rdy_i = 1'b1;
    while (!chien_rdy_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("start_rdy_wait", chien_rdy_o, 1);
    chien_start_i = 1'b1;
    lambda_deg_i  = deg;
    lambda_fail_i = fail;
    @(posedge clk); #1;
    chien_start_i = 1'b0;
    lambda_fail_i = 1'b0;
    for (int i = 0; i < h_pos.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          chien_vld_i  = 1'($urandom_range(0, 1));
          chien_hit_i  = 1'b0;
          chien_last_i = 1'b0;
          chien_pos_i  = 10'($urandom_range(0, N - 1));
          chien_y_i    = W'($urandom);
          @(posedge clk); #1;
        end
      end
      chien_vld_i  = 1'b1;
      chien_hit_i  = 1'b1;
      chien_pos_i  = h_pos[i];
      chien_y_i    = h_y[i];
      chien_last_i = last_hit && (i == h_pos.size() - 1);
      c = cyc;
      @(posedge clk); #1;
    end
    if (!(last_hit && h_pos.size() > 0)) begin
      chien_vld_i  = 1'b1;
      chien_hit_i  = 1'b0;
      chien_pos_i  = 10'($urandom_range(0, N - 1));
      chien_y_i    = W'($urandom);
      chien_last_i = 1'b1;
      c = cyc;
      @(posedge clk); #1;
    end
    chien_vld_i  = 1'b0;
    chien_hit_i  = 1'b0;
    chien_last_i = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int c, input bit exp_exc, input int exp_ev);
    int t;
    int tt;
    int exp_done;
    int hs[$];
    t = 0;
    while (d_cyc.size() == 0 && t < 400) begin
      forney_rdy_i = rdy_at(cyc - c);
      @(posedge clk); #1;
      t++;
    end
    forney_rdy_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tt = c + 2;
    for (int k = 0; k < exp_ev; k++) begin
      while (!rdy_at(tt - c)) tt++;
      hs.push_back(tt);
      tt++;
    end
    exp_done = (exp_ev > 0) ? hs[exp_ev - 1] + 1 : c + 2;
    chk({tag, " verdict_count"}, v_cyc.size(), 1);
    if (v_cyc.size() > 0) begin
      chk({tag, " verdict_cycle"}, v_cyc[0] - c, 1);
      chk({tag, " exceed"}, v_exc[0], exp_exc);
    end
    chk({tag, " event_count"}, e_pos.size(), exp_ev);
    for (int k = 0; k < e_pos.size() && k < exp_ev; k++) begin
      chk({tag, " event_pos"}, e_pos[k], h_pos[k]);
      chk({tag, " event_y"}, e_y[k], h_y[k]);
      chk({tag, " event_cycle"}, e_cyc[k] - c, hs[k] - c);
    end
    chk({tag, " done_count"}, d_cyc.size(), 1);
    if (d_cyc.size() > 0) chk({tag, " done_cycle"}, d_cyc[0] - c, exp_done - c);
  endtask

  typedef struct {
    logic [4:0] deg;
    bit         fail;
    int         nhits;
    int         bad_idx;
    bit         last_hit;
    int         stall;
    bit         exp_exc;
    int         exp_ev;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int c;
    vecs[0] = '{5'd3,  1'b0, 3,  -1, 1'b1, 0, 1'b0, 3};   // clean
    vecs[1] = '{5'd4,  1'b0, 3,  -1, 1'b0, 0, 1'b1, 0};   // degree mismatch
    vecs[2] = '{5'd11, 1'b0, 12, -1, 1'b1, 0, 1'b1, 0};   // overflow
    vecs[3] = '{5'd11, 1'b0, 11, -1, 1'b1, 0, 1'b0, 11};  // exactly T events
    vecs[4] = '{5'd2,  1'b0, 2,  -1, 1'b1, 5, 1'b0, 2};   // backpressure
    vecs[5] = '{5'd1,  1'b0, 1,  0,  1'b1, 0, 1'b1, 0};   // out-of-range position
    vecs[6] = '{5'd0,  1'b1, 0,  -1, 1'b0, 0, 1'b1, 0};   // BM failure, no hits
    vecs[7] = '{5'd0,  1'b0, 0,  -1, 1'b0, 0, 1'b0, 0};   // no errors
    vecs[8] = '{5'd12, 1'b0, 12, -1, 1'b0, 0, 1'b1, 0};   // count above T, deg agrees
    vecs[9] = '{5'd10, 1'b0, 11, -1, 1'b0, 3, 1'b1, 0};   // full FIFO, deg mismatch
    rdy_all_ones();

    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("reset_rdy", chien_rdy_o, 1);
    chk("reset_outs_zero", {ecc_valid_o, exceed_o, forney_vld_o, forney_pos_o, forney_y_o,
                            recorrect_done_o, proto_err_o}, 0);

    // Beat in IDLE flags a protocol error; reset clears it
    @(posedge clk); #1;
    chien_vld_i = 1'b1;
    @(posedge clk); #1;
    chien_vld_i = 1'b0;
    @(negedge clk);
    chk("proto_idle_beat", proto_err_o, 1);
    @(posedge clk); #1;
    chk("proto_sticky", proto_err_o, 1);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("proto_reset_clear", proto_err_o, 0);

    // Start repeated inside COLLECT
    @(posedge clk); #1;
    chien_start_i = 1'b1;
    lambda_deg_i  = 5'd0;
    @(posedge clk); #1;
    chien_vld_i  = 1'b1;
    chien_last_i = 1'b1;
    @(posedge clk); #1;
    chien_start_i = 1'b0;
    chien_vld_i   = 1'b0;
    chien_last_i  = 1'b0;
    @(negedge clk);
    chk("proto_start_in_collect", proto_err_o, 1);
    repeat (4) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;

    // Directed table
    for (int v = 0; v < 10; v++) begin
      h_pos.delete();
      h_y.delete();
      for (int i = 0; i < vecs[v].nhits; i++) begin
        h_pos.push_back((i == vecs[v].bad_idx) ? 10'd600 : 10'((i * 47 + 3) % N));
        h_y.push_back(W'((i * 73 + 17) % 1024));
      end
      rdy_all_ones();
      for (int k = 2; k < 2 + vecs[v].stall; k++) rdy_pat[k] = 1'b0;
      drive_frame(vecs[v].deg, vecs[v].fail, vecs[v].last_hit, 1'b0, c);
      check_frame($sformatf("vec%0d", v), c, vecs[v].exp_exc, vecs[v].exp_ev);
    end

    // Reset during DRAIN after the first of three events
    h_pos = '{10'd7, 10'd200, 10'd300};
    h_y   = '{W'(10'h0AA), W'(10'h155), W'(10'h2F0)};
    for (int k = 0; k < 512; k++) rdy_pat[k] = 1'b0;
    rdy_pat[2] = 1'b1;
    drive_frame(5'd3, 1'b0, 1'b1, 1'b0, c);
    while (cyc < c + 3) begin
      forney_rdy_i = rdy_at(cyc - c);
      @(posedge clk); #1;
    end
    forney_rdy_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    forney_rdy_i = 1'b1;
    @(negedge clk);
    chk("rst_drain_rdy", chien_rdy_o, 1);
    chk("rst_drain_outs_zero", {ecc_valid_o, exceed_o, forney_vld_o, forney_pos_o, forney_y_o,
                                recorrect_done_o, proto_err_o}, 0);
    chk("rst_drain_events_sent", e_pos.size(), 1);
    repeat (10) @(posedge clk);
    #1;
    chk("rst_drain_no_done", d_cyc.size(), 0);
    chk("rst_drain_no_extra_events", e_pos.size(), 1);

    // Clean frame with the reference positions, right after the aborted one
    h_pos = '{10'd5, 10'd100, 10'd543};
    h_y   = '{W'(10'h011), W'(10'h3FF), W'(10'h001)};
    rdy_all_ones();
    drive_frame(5'd3, 1'b0, 1'b1, 1'b0, c);
    check_frame("clean", c, 1'b0, 3);
    chk("clean_done_at_c5", (d_cyc.size() > 0) ? d_cyc[0] - c : -1, 5);

    // Random frames
    for (int f = 0; f < 40; f++) begin
      int  nh;
      int  ne;
      bit  fl;
      bit  lh;
      bit  ex;
      logic [4:0] dg;
      nh = $urandom_range(0, 13);
      h_pos.delete();
      h_y.delete();
      for (int i = 0; i < nh; i++) begin
        h_pos.push_back(10'($urandom_range(0, N - 1)));
        h_y.push_back(W'($urandom));
      end
      if (nh > 0 && $urandom_range(0, 9) == 0) h_pos[$urandom_range(0, nh - 1)] = 10'($urandom_range(N, 1023));
      dg = ($urandom_range(0, 1) == 1) ? 5'(nh) : 5'($urandom_range(0, 15));
      fl = ($urandom_range(0, 9) == 0);
      lh = 1'($urandom_range(0, 1));
      for (int k = 0; k < 512; k++) rdy_pat[k] = (f % 2 == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
      ex = ref_exceed(dg, fl);
      ne = (ex || nh == 0) ? 0 : nh;
      drive_frame(dg, fl, lh, 1'b1, c);
      check_frame($sformatf("rand%0d", f), c, ex, ne);
    end

    chk("proto_clean_run", proto_err_o, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/forney_evt_tx.md
# forney_evt_tx

Transmit side of the Forney event interface of the RS(544,522) decoder. Per frame it collects error hits from the Chien/Forney stage in a small FIFO. It then decides correctability and issues the `ecc_valid_o`/`exceed_o` verdict. Accepted events are drained one per handshake toward the reorder control path, and every frame ends with exactly one `recorrect_done_o` pulse so downstream ping-pong bank selection stays aligned.

## Interface
Parameters:
- `W`, 10: symbol width (GF(2^10)).
- `N`, 544: codeword length; valid positions are 0..N-1.
- `T`, 11: correction capability; sets FIFO depth and the maximum number of accepted errors.

Ports:
- `clk_i` input 1: single clock.
- `rst_i` input 1: reset, synchronous, active-high.
- `chien_start_i` input 1: frame start pulse; `lambda_deg_i` and `lambda_fail_i` are valid in the same cycle.
- `lambda_deg_i` input 5: degree of the error-locator polynomial.
- `lambda_fail_i` input 1: Berlekamp-Massey failure flag.
- `chien_vld_i` input 1: one position beat.
- `chien_hit_i` input 1: the beat's position is an error root.
- `chien_pos_i` input 10: position in the GF direct-address domain.
- `chien_y_i` input W: error magnitude.
- `chien_last_i` input 1: marks the final beat of the frame.
- `chien_rdy_o` output 1: block accepts start and beats.
- `ecc_valid_o` output 1: one-cycle verdict pulse.
- `exceed_o` output 1: verdict value, valid only while `ecc_valid_o` is high.
- `forney_vld_o` output 1: event valid.
- `forney_pos_o` output 10: event position.
- `forney_y_o` output W: event magnitude.
- `forney_rdy_i` input 1: downstream ready.
- `recorrect_done_o` output 1: one-cycle end-of-frame pulse.
- `proto_err_o` output 1: sticky protocol-violation flag.

## Operation
- States: IDLE, COLLECT, JUDGE, DRAIN, DONE.
- IDLE:
  - `chien_rdy_o`=1.
  - On `chien_start_i`: latch `deg`=`lambda_deg_i` and `fail`=`lambda_fail_i`, clear `hit_cnt` and `oor`, flush the FIFO, go to COLLECT.
  - Beats arriving in IDLE are ignored and set `proto_err_o`.
- COLLECT:
  - `chien_rdy_o`=1.
  - Each beat with `chien_vld_i` and `chien_hit_i` increments `hit_cnt`, saturating at T+1.
  - It pushes {pos, y} only when `hit_cnt`<T and pos<N.
  - pos≥N sets `oor`.
  - A beat with `chien_vld_i` and `chien_last_i` moves to JUDGE; that last beat's hit is counted first.
  - `chien_start_i` in COLLECT is ignored and sets `proto_err_o`.
- JUDGE (one cycle):
  - `ecc_valid_o`=1.
  - `exceed_o` = `fail` | `oor` | (`hit_cnt`>T) | (`hit_cnt`≠`deg`).
  - Exceed, or `hit_cnt`=0: flush the FIFO and go to DONE.
  - Otherwise go to DRAIN.
- DRAIN:
  - `forney_vld_o` = FIFO not empty, driven from the FIFO head.
  - Pop on `forney_vld_o`&`forney_rdy_i`; pos/y hold stable while stalled.
  - The handshake that pops the last entry moves to DONE.
- DONE (one cycle): `recorrect_done_o`=1, then go to IDLE.
- `chien_rdy_o`=0 in JUDGE, DRAIN and DONE; upstream must hold.
- Events leave in arrival order, at most one per cycle.
- Widths:
  - `hit_cnt` is $clog2(T+2) bits.
  - The `deg` compare zero-extends to the wider operand.

## Timing
- Reset (`rst_i` high at a clock edge):
  - State goes to IDLE and the FIFO is emptied.
  - All outputs are 0 except `chien_rdy_o`=1.
  - `proto_err_o` clears.
  - Reset mid-frame discards the frame: no verdict and no `recorrect_done_o`.
- Cycle numbering from the last beat at cycle c:
  - `ecc_valid_o` is at c+1.
  - The first `forney_vld_o` is at c+2.
  - `recorrect_done_o` comes one cycle after the final pop handshake; for exceed or zero hits it is at c+2.
- Minimum frame turnaround, last beat to next start accepted: 3 cycles + drain.
- With `forney_rdy_i` held at 1, K events occupy K consecutive cycles.
- A hit that arrives when the FIFO already holds T entries is counted but not stored; the frame becomes exceed via `hit_cnt`>T.
- All outputs are registered except `chien_rdy_o` and the `forney_*` outputs, which come from the FIFO head register.

## Structure
- `reorder_pkg` holds the state enum `evt_tx_state_e` and the constants `RS_N`=544, `RS_T`=11, `RS_W`=10.
- Sub-module `evt_fifo` is a synchronous fall-through FIFO:
  - Depth T, width 10+W.
  - Ports: push, pop, flush, empty, full.
  - Flush has priority over push.
- The top level contains the FSM, counters and verdict logic only.

## Test plan
- Clean frame: deg=3, hits at pos 5, 100, 543 with y=0x011, 0x3FF, 0x001, rdy=1 → `ecc_valid_o` with `exceed_o`=0 at c+1; events 5, 100, 543 on c+2..c+4; `recorrect_done_o` at c+5.
- Degree mismatch: deg=4, 3 hits → `exceed_o`=1; no `forney_vld_o`; `recorrect_done_o` at c+2.
- Overflow: deg=11, 12 hits → 11 hits are stored, then exceed=1; FIFO is flushed; zero events are emitted; done pulse is still issued.
- Backpressure: 2 events, `forney_rdy_i` low for 5 cycles → pos/y stable throughout; each event pops exactly once; done follows the second handshake.
- Out-of-range and BM failure: a hit at pos 600 → exceed=1; separately, `lambda_fail_i`=1 with 0 hits → exceed=1; both end with a done pulse.
- Reset during DRAIN with 1 of 3 events sent → all outputs go to reset values next cycle; no done pulse; the next frame behaves normally.
